// File: rtl/sram_banked_dualport_if.sv
`default_nettype none
// ============================================================================
// Module : sram_banked_dualport_if
// Brief  : Two-port request/response bundle; port 1 occupies the upper half.
// Rev    : 1.0
// ============================================================================
interface sram_banked_dualport_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 9,
  parameter int BE_BITS   = WIDTH / 8
);
  logic [1:0]             ReqValid;
  logic [1:0]             ReqReady;
  logic [1:0]             ReqWrEn;
  logic [2*ADDR_BITS-1:0] ReqAddr;
  logic [2*WIDTH-1:0]     ReqWrData;
  logic [2*BE_BITS-1:0]   ReqByteEn;
  logic [1:0]             RspValid;
  logic [2*WIDTH-1:0]     RspData;
  logic [15:0]            ConflictCount;

  modport master (
    output ReqValid, ReqWrEn, ReqAddr, ReqWrData, ReqByteEn,
    input  ReqReady, RspValid, RspData, ConflictCount
  );

  modport slave (
    input  ReqValid, ReqWrEn, ReqAddr, ReqWrData, ReqByteEn,
    output ReqReady, RspValid, RspData, ConflictCount
  );
endinterface
`default_nettype wire

// File: rtl/sram_banked_dualport.sv
`default_nettype none
// ============================================================================
// Module : sram_banked_dualport
// Brief  : Low-order-interleaved banked SRAM shared by two request ports with
//          round-robin bank-conflict arbitration and 1-cycle read responses.
// Rev    : 1.0
// ============================================================================
module sram_banked_dualport #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int BANK_BITS = $clog2(NUM_BANKS),
  parameter int BE_BITS   = WIDTH / 8
) (
  input  logic                  Clk,
  input  logic                  RstN,
  sram_banked_dualport_if.slave bus
);
  localparam int ROWS     = DEPTH / NUM_BANKS;
  localparam int ROW_BITS = ADDR_BITS - BANK_BITS;

  logic [1:0][BANK_BITS-1:0]       w_bank;
  logic [1:0][ROW_BITS-1:0]        w_row;
  logic [1:0][WIDTH-1:0]           w_wdata;
  logic [1:0][BE_BITS-1:0]         w_be;
  logic                            w_conflict;
  logic [1:0]                      w_ready;
  logic [1:0]                      w_rd_fire;
  logic [NUM_BANKS-1:0][WIDTH-1:0] w_bank_rdata;

  logic                  prio_q, prio_d;
  logic [15:0]           conflict_cnt_q, conflict_cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_bank[p]  = bus.ReqAddr[p*ADDR_BITS +: BANK_BITS];
      w_row[p]   = bus.ReqAddr[p*ADDR_BITS + BANK_BITS +: ROW_BITS];
      w_wdata[p] = bus.ReqWrData[p*WIDTH +: WIDTH];
      w_be[p]    = bus.ReqByteEn[p*BE_BITS +: BE_BITS];
    end
  end

  // Reset gates every grant so nothing reaches the banks while RstN is low.
  assign w_conflict = RstN && (&bus.ReqValid) && (w_bank[0] == w_bank[1]);
  assign w_ready[0] = RstN && bus.ReqValid[0] && (!w_conflict || !prio_q);
  assign w_ready[1] = RstN && bus.ReqValid[1] && (!w_conflict ||  prio_q);
  assign w_rd_fire  = w_ready & ~bus.ReqWrEn;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0]    mem_q [ROWS];
    logic                w_hit0;
    logic                w_hit1;
    logic                w_sel;
    logic [ROW_BITS-1:0] w_brow;

    // At most one port can hold a grant to this bank in any cycle.
    assign w_hit0 = w_ready[0] && (w_bank[0] == BANK_BITS'(b));
    assign w_hit1 = w_ready[1] && (w_bank[1] == BANK_BITS'(b));
    assign w_sel  = w_hit1;
    assign w_brow = w_sel ? w_row[1] : w_row[0];
    assign w_bank_rdata[b] = mem_q[w_brow];

    always_ff @(posedge Clk) begin
      if ((w_hit0 || w_hit1) && bus.ReqWrEn[w_sel]) begin
        for (int i = 0; i < BE_BITS; i++) begin
          if (w_be[w_sel][i]) begin
            mem_q[w_brow][i*8 +: 8] <= w_wdata[w_sel][i*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d    = w_rd_fire;
    rsp_data_d     = rsp_data_q;
    prio_d         = prio_q;
    conflict_cnt_d = conflict_cnt_q;
    for (int p = 0; p < 2; p++) begin
      if (w_rd_fire[p]) begin
        rsp_data_d[p] = w_bank_rdata[w_bank[p]];
      end
    end
    if (w_conflict) begin
      prio_d = ~prio_q;
      if (conflict_cnt_q != 16'hFFFF) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      prio_q         <= 1'b0;
      conflict_cnt_q <= 16'd0;
      rsp_valid_q    <= 2'b00;
      rsp_data_q     <= '0;
    end else begin
      prio_q         <= prio_d;
      conflict_cnt_q <= conflict_cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign bus.ReqReady      = w_ready;
  assign bus.RspValid      = rsp_valid_q;
  assign bus.RspData       = rsp_data_q;
  assign bus.ConflictCount = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_banked_dualport.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_banked_dualport
// Brief  : Randomized and directed bench for sram_banked_dualport against a
//          word-array reference model.
// Rev    : 1.0
// ============================================================================
module tb_sram_banked_dualport;
  localparam int NB    = 4;
  localparam int DEPTH = 512;

  logic Clk = 1'b0;
  logic RstN = 1'b0;
  always #5 Clk = ~Clk;

  sram_banked_dualport_if #(.WIDTH(32), .ADDR_BITS(9), .BE_BITS(4)) bus ();

  sram_banked_dualport #(
    .WIDTH(32), .DEPTH(DEPTH), .NUM_BANKS(NB)
  ) dut (
    .Clk (Clk),
    .RstN(RstN),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_m [2];
  logic        prio_m;
  int          cnt_m;
  logic [1:0]  acc_v;
  int          cnt_save;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive, check grants, clock, check responses.
  task automatic cycle(input logic [1:0] v, input logic [1:0] we,
                       input int a0, input int a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] be0, input logic [3:0] be1,
                       output logic [1:0] acc);
    int          a  [2];
    logic [31:0] d  [2];
    logic [3:0]  be [2];
    logic [1:0]  rv;
    a[0] = a0;   a[1] = a1;
    d[0] = d0;   d[1] = d1;
    be[0] = be0; be[1] = be1;
    bus.ReqValid  = v;
    bus.ReqWrEn   = we;
    bus.ReqAddr   = {9'(a1), 9'(a0)};
    bus.ReqWrData = {d1, d0};
    bus.ReqByteEn = {be1, be0};
    #1;
    acc = v;
    if (v == 2'b11 && (a0 % NB) == (a1 % NB)) begin
      acc    = prio_m ? 2'b10 : 2'b01;
      prio_m = ~prio_m;
      if (cnt_m < 65535) cnt_m = cnt_m + 1;
    end
    check_value("ready", 64'(bus.ReqReady), 64'(acc));
    rv = acc & ~we;
    for (int p = 0; p < 2; p++)
      if (rv[p]) last_m[p] = mem_m[a[p]];
    for (int p = 0; p < 2; p++)
      if (acc[p] && we[p])
        for (int i = 0; i < 4; i++)
          if (be[p][i]) mem_m[a[p]][8*i +: 8] = d[p][8*i +: 8];
    @(posedge Clk);
    #1;
    bus.ReqValid = 2'b00;
    check_value("rsp_valid", 64'(bus.RspValid), 64'(rv));
    check_value("rsp_data", bus.RspData, {last_m[1], last_m[0]});
    check_value("conflict_count", 64'(bus.ConflictCount), 64'(cnt_m));
  endtask

  // Reset with live write requests on both ports; none may land.
  task automatic do_reset();
    bus.ReqValid  = 2'b11;
    bus.ReqWrEn   = 2'b11;
    bus.ReqAddr   = {9'd14, 9'd13};
    bus.ReqWrData = {32'hBAD0_0001, 32'hBAD0_0000};
    bus.ReqByteEn = 8'hFF;
    RstN = 1'b0;
    #1;
    check_value("rst_ready", 64'(bus.ReqReady), 64'd0);
    @(posedge Clk);
    #1;
    prio_m    = 1'b0;
    cnt_m     = 0;
    last_m[0] = '0;
    last_m[1] = '0;
    check_value("rst_rsp_valid", 64'(bus.RspValid), 64'd0);
    check_value("rst_rsp_data", bus.RspData, 64'd0);
    check_value("rst_conflict_count", 64'(bus.ConflictCount), 64'd0);
    RstN = 1'b1;
    bus.ReqValid = 2'b00;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  pv, pwe;
    int          pa  [2];
    logic [31:0] pd  [2];
    logic [3:0]  pbe [2];

    bus.ReqValid = 2'b00; bus.ReqWrEn = 2'b00; bus.ReqAddr = '0;
    bus.ReqWrData = '0;   bus.ReqByteEn = '0;
    @(posedge Clk);
    #1;
    do_reset();

    // Write then read back on port 0.
    cycle(2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, acc_v);
    cycle(2'b01, 2'b00, 5, 0, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("t1_valid", 64'(bus.RspValid[0]), 64'd1);
    check_value("t1_data", 64'(bus.RspData[31:0]), 64'hDEADBEEF);

    // Byte-masked writes, including an empty mask.
    cycle(2'b01, 2'b01, 8, 0, 32'h11223344, 32'h0, 4'hF, 4'h0, acc_v);
    cycle(2'b01, 2'b01, 8, 0, 32'hAABBCCDD, 32'h0, 4'b0101, 4'h0, acc_v);
    cycle(2'b01, 2'b00, 8, 0, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("mask_data", 64'(bus.RspData[31:0]), 64'h11BB33DD);
    cycle(2'b01, 2'b01, 8, 0, 32'hFFFFFFFF, 32'h0, 4'h0, 4'h0, acc_v);
    cycle(2'b01, 2'b00, 8, 0, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("mask_zero_data", 64'(bus.RspData[31:0]), 64'h11BB33DD);

    // Fill every word so later reads are fully defined.
    for (int a = 0; a < DEPTH; a += 2)
      cycle(2'b11, 2'b11, a, a + 1, $urandom, $urandom, 4'hF, 4'hF, acc_v);

    // Parallel reads on different banks.
    cnt_save = cnt_m;
    cycle(2'b11, 2'b00, 4, 7, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("par_valid", 64'(bus.RspValid), 64'd3);
    check_value("par_count", 64'(bus.ConflictCount), 64'(cnt_save));

    // Round-robin under continuous same-bank contention.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(2'b11, 2'b00, 1, 9, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
      check_value("rr_winner", 64'(bus.RspValid), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    check_value("rr_count", 64'(bus.ConflictCount), 64'd4);

    // Random traffic; stalled requests are held until granted.
    pv = 2'b00;
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p]) begin
          pv[p]  = ($urandom_range(0, 3) != 0);
          pwe[p] = $urandom_range(0, 1) != 0;
          pa[p]  = $urandom_range(0, DEPTH - 1);
          pd[p]  = $urandom;
          pbe[p] = 4'($urandom_range(0, 15));
        end
      end
      cycle(pv, pwe, pa[0], pa[1], pd[0], pd[1], pbe[0], pbe[1], acc_v);
      pv = pv & ~acc_v;
    end

    // Reset right after a port-1 read is accepted.
    cycle(2'b10, 2'b00, 0, 13, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    do_reset();
    cycle(2'b11, 2'b00, 2, 6, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("post_rst_winner", 64'(bus.RspValid), 64'd1);
    cycle(2'b10, 2'b00, 0, 13, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    cycle(2'b10, 2'b00, 0, 14, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);

    // Counter saturation.
    for (int n = 0; n < 70000; n++)
      cycle(2'b11, 2'b00, 1, 9, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("sat_count", 64'(bus.ConflictCount), 64'hFFFF);
    cycle(2'b11, 2'b00, 3, 7, 32'h0, 32'h0, 4'h0, 4'h0, acc_v);
    check_value("sat_hold", 64'(bus.ConflictCount), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
